// File: rtl/tlb_op_if.sv
// tlb_op_if: execute-stage request/response channel of the TLB op controller
interface tlb_op_if #(
    parameter int IDXW    = 4,
    parameter int ENTRY_W = 89
);
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op_code;
    logic [4:0]         inv_op;
    logic [9:0]         inv_asid;
    logic [18:0]        inv_vppn;
    logic [IDXW-1:0]    csr_index;
    logic               csr_ne;
    logic [5:0]         csr_ecode;
    logic [ENTRY_W-1:0] csr_entry;
    logic               done;
    logic               res_hit;
    logic [IDXW-1:0]    res_index;
    logic [ENTRY_W-1:0] res_entry;
    logic               inv_err;

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_ne, csr_ecode, csr_entry,
        input  op_ready, done, res_hit, res_index, res_entry, inv_err
    );

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_ne, csr_ecode, csr_entry,
        output op_ready, done, res_hit, res_index, res_entry, inv_err
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB array ports
module tlb_op_ctrl #(
    parameter int TLBNUM  = 16,
    parameter int IDXW    = $clog2(TLBNUM),
    parameter int ENTRY_W = 89
) (
    input  logic               clk,
    input  logic               reset,
    tlb_op_if.slave            op,
    output logic [18:0]        s_vppn,
    output logic [9:0]         s_asid,
    input  logic               s_hit,
    input  logic [IDXW-1:0]    s_index,
    output logic [IDXW-1:0]    t_index,
    input  logic [ENTRY_W-1:0] t_entry,
    output logic               w_en,
    output logic [IDXW-1:0]    w_index,
    output logic [ENTRY_W-1:0] w_entry,
    output logic               clr_en
);
    localparam int E_B      = 52;
    localparam int G_B      = 63;
    localparam int ASID_LSB = 53;
    localparam int VPPN_LSB = 70;

    typedef enum logic [2:0] {IDLE, SRCH, RD, WR, INV, DONE} state_t;

    state_t             state, state_n;
    logic [IDXW-1:0]    fill_ctr, idx_q, scan;
    logic [ENTRY_W-1:0] went_q;
    logic [2:0]         iop_q;
    logic               err_q;
    logic [9:0]         asid_q;
    logic [18:0]        vppn_q;
    logic               accept, g, asid_eq, vppn_eq, match;

    assign accept     = op.op_valid && state == IDLE;
    assign op.op_ready = state == IDLE;
    assign op.done    = state == DONE;
    assign op.inv_err = state == DONE && err_q;
    assign w_en       = state == WR;
    assign w_index    = idx_q;
    assign w_entry    = went_q;
    assign t_index    = state == INV ? scan : state == RD ? idx_q : '0;

    assign g       = t_entry[G_B];
    assign asid_eq = t_entry[ASID_LSB +: 10] == asid_q;
    assign vppn_eq = t_entry[VPPN_LSB +: 19] == vppn_q;
    assign match   = iop_q <= 3'd1 ? 1'b1 :
                     iop_q == 3'd2 ? g :
                     iop_q == 3'd3 ? !g :
                     iop_q == 3'd4 ? !g && asid_eq :
                     iop_q == 3'd5 ? !g && asid_eq && vppn_eq :
                     (g || asid_eq) && vppn_eq;
    assign clr_en  = state == INV && !err_q && t_entry[E_B] && match;

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state: every op lands in DONE for exactly one cycle before IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (accept) state_n = op.op_code == 3'd0 ? SRCH :
                                                op.op_code == 3'd1 ? RD :
                                                op.op_code inside {3'd2, 3'd3} ? WR : INV;
            SRCH, RD, WR: state_n = DONE;
            INV:          if (err_q || scan == IDXW'(TLBNUM - 1)) state_n = DONE;
            default:      state_n = IDLE;
        endcase
    end

    // operand latch at accept, free-running fill counter, result capture and scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_ctr     <= '0;
            idx_q        <= '0;
            went_q       <= '0;
            iop_q        <= '0;
            err_q        <= 1'b0;
            asid_q       <= '0;
            vppn_q       <= '0;
            scan         <= '0;
            s_vppn       <= '0;
            s_asid       <= '0;
            op.res_hit   <= 1'b0;
            op.res_index <= '0;
            op.res_entry <= '0;
        end else begin
            fill_ctr <= fill_ctr + IDXW'(1);
            if (accept) begin
                idx_q        <= op.op_code == 3'd3 ? fill_ctr : op.csr_index;
                went_q       <= {op.csr_entry[ENTRY_W-1:E_B+1], op.csr_ecode == 6'h3F || !op.csr_ne,
                                 op.csr_entry[E_B-1:0]};
                iop_q        <= op.inv_op[2:0];
                err_q        <= op.op_code > 3'd4 || (op.op_code == 3'd4 && op.inv_op > 5'd6);
                asid_q       <= op.inv_asid;
                vppn_q       <= op.inv_vppn;
                scan         <= '0;
                op.res_hit   <= 1'b0;
                op.res_index <= '0;
                op.res_entry <= '0;
                if (op.op_code == 3'd0) begin
                    s_vppn <= op.csr_entry[VPPN_LSB +: 19];
                    s_asid <= op.csr_entry[ASID_LSB +: 10];
                end
            end
            if (state == SRCH) begin
                op.res_hit   <= s_hit;
                op.res_index <= s_index;
            end
            if (state == RD) begin
                op.res_hit   <= t_entry[E_B];
                op.res_entry <= t_entry[E_B] ? t_entry : '0;
            end
            if (state == INV) scan <= scan + IDXW'(1);
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed and randomized checks of tlb_op_ctrl against a behavioural TLB reference
module tb_tlb_op_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int EW = 89;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [18:0]   s_vppn;
    logic [9:0]    s_asid;
    logic          s_hit;
    logic [IW-1:0] s_index, t_index, w_index;
    logic [EW-1:0] t_entry, w_entry;
    logic          w_en, clr_en;

    tlb_op_if #(.IDXW(IW), .ENTRY_W(EW)) bus ();

    tlb_op_ctrl #(.TLBNUM(N)) dut (
        .clk(clk), .reset(reset), .op(bus),
        .s_vppn(s_vppn), .s_asid(s_asid), .s_hit(s_hit), .s_index(s_index),
        .t_index(t_index), .t_entry(t_entry),
        .w_en(w_en), .w_index(w_index), .w_entry(w_entry), .clr_en(clr_en)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] tlb     [N];
    logic [EW-1:0] ref_mem [N];
    int            ref_fill = 0;
    int            errs = 0, checks = 0;

    int            lat, wcnt, wcyc, tbad, both, cap_fill;
    logic [IW-1:0] widx, ridx;
    logic [EW-1:0] went, rent;
    logic [N-1:0]  clrs;
    logic          rhit, rerr;

    assign t_entry = tlb[t_index];

    always_comb begin
        s_hit   = 1'b0;
        s_index = '0;
        for (int i = 0; i < N; i++)
            if (tlb[i][52] && tlb[i][88:70] == s_vppn && (tlb[i][63] || tlb[i][62:53] == s_asid)) begin
                s_hit   = 1'b1;
                s_index = IW'(i);
            end
    end

    always @(posedge clk) begin
        if (w_en) tlb[w_index] = w_entry;
        if (clr_en) tlb[t_index][52] = 1'b0;
    end

    always @(posedge clk) ref_fill <= reset ? 0 : (ref_fill + 1) % N;

    function automatic logic [EW-1:0] mk(input logic [18:0] v, input logic g, input logic [9:0] a, input logic e);
        return {v, 6'($urandom_range(0, 63)), g, a, e, 26'($urandom), 26'($urandom)};
    endfunction

    function automatic logic [18:0] pick_vppn();
        int r = $urandom_range(0, 2);
        return r == 0 ? 19'h12345 : r == 1 ? 19'h0ABCD : 19'($urandom);
    endfunction

    function automatic logic [9:0] pick_asid();
        return $urandom_range(0, 1) == 1 ? 10'h3 : 10'h4;
    endfunction

    function automatic bit inv_hits(input int o, input logic [EW-1:0] e, input logic [9:0] a, input logic [18:0] v);
        bit gl = e[63];
        bit am = e[62:53] == a;
        bit vm = e[88:70] == v;
        if (!e[52]) return 0;
        if (o <= 1) return 1;
        if (o == 2) return gl;
        if (o == 3) return !gl;
        if (o == 4) return !gl && am;
        if (o == 5) return !gl && am && vm;
        return (gl || am) && vm;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op_run(input logic [2:0] code);
        bus.op_code  = code;
        bus.op_valid = 1'b1;
        chk("ready_at_issue", 96'(bus.op_ready), 96'(1));
        cap_fill = ref_fill;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        lat = 0; wcnt = 0; wcyc = 0; tbad = 0; both = 0; clrs = '0;
        widx = '0; went = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= N && t_index != IW'(k - 1)) tbad++;
            if (w_en && clr_en) both++;
            if (w_en) begin wcnt++; wcyc = k; widx = w_index; went = w_entry; end
            if (clr_en) clrs[t_index] = 1'b1;
            if (bus.done) begin
                lat = k; rhit = bus.res_hit; ridx = bus.res_index; rent = bus.res_entry; rerr = bus.inv_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("ready_after_done", 96'(bus.op_ready), 96'(1));
    endtask

    task automatic do_write(input logic [2:0] code, input logic [IW-1:0] idx, input logic [EW-1:0] e,
                            input logic ne, input logic [5:0] ec);
        logic [EW-1:0] exp_e = e;
        int            exp_i;
        bus.csr_index = idx; bus.csr_entry = e; bus.csr_ne = ne; bus.csr_ecode = ec;
        op_run(code);
        exp_e[52] = ec == 6'h3F || !ne;
        exp_i     = code == 3'd3 ? cap_fill : int'(idx);
        chk("wr_latency", 96'(lat), 96'(2));
        chk("wr_pulses", 96'(wcnt), 96'(1));
        chk("wr_cycle", 96'(wcyc), 96'(1));
        chk("wr_index", 96'(widx), 96'(exp_i));
        chk("wr_entry", 96'(went), 96'(exp_e));
        chk("wr_no_clr", 96'(clrs), 96'(0));
        ref_mem[exp_i] = exp_e;
    endtask

    task automatic do_srch(input logic [18:0] v, input logic [9:0] a);
        bit hit = 0;
        int hi = 0;
        for (int i = 0; i < N; i++)
            if (ref_mem[i][52] && ref_mem[i][88:70] == v && (ref_mem[i][63] || ref_mem[i][62:53] == a)) begin
                hit = 1; hi = i;
            end
        bus.csr_entry = mk(v, 1'($urandom), a, 1'($urandom));
        op_run(3'd0);
        chk("srch_latency", 96'(lat), 96'(2));
        chk("srch_hit", 96'(rhit), 96'(hit));
        if (hit) chk("srch_index", 96'(ridx), 96'(hi));
        chk("srch_no_access", 96'({wcnt, clrs}), 96'(0));
    endtask

    task automatic do_rd(input logic [IW-1:0] idx);
        bus.csr_index = idx;
        op_run(3'd1);
        chk("rd_latency", 96'(lat), 96'(2));
        chk("rd_hit", 96'(rhit), 96'(ref_mem[idx][52]));
        chk("rd_entry", 96'(rent), 96'(ref_mem[idx][52] ? ref_mem[idx] : '0));
    endtask

    task automatic do_inv(input logic [2:0] code, input logic [4:0] iop, input logic [9:0] a, input logic [18:0] v);
        bit           legal = code == 3'd4 && iop <= 5'd6;
        logic [N-1:0] mask = '0;
        for (int i = 0; i < N; i++) if (legal && inv_hits(int'(iop), ref_mem[i], a, v)) mask[i] = 1'b1;
        bus.inv_op = iop; bus.inv_asid = a; bus.inv_vppn = v;
        op_run(code);
        chk("inv_latency", 96'(lat), 96'(legal ? N + 1 : 2));
        chk("inv_err", 96'(rerr), 96'(!legal));
        chk("inv_clr_set", 96'(clrs), 96'(mask));
        chk("inv_no_write_overlap", 96'({wcnt, both}), 96'(0));
        if (legal) chk("inv_scan_order", 96'(tbad), 96'(0));
        for (int i = 0; i < N; i++) if (mask[i]) ref_mem[i][52] = 1'b0;
    endtask

    task automatic load(input int i, input logic [EW-1:0] e);
        tlb[i] = e;
        ref_mem[i] = e;
    endtask

    initial begin
        logic [EW-1:0] e;
        int            bad, pulses;
        bus.op_valid = 0; bus.op_code = 0; bus.inv_op = 0; bus.inv_asid = 0; bus.inv_vppn = 0;
        bus.csr_index = 0; bus.csr_ne = 0; bus.csr_ecode = 0; bus.csr_entry = 0;
        for (int i = 0; i < N; i++) load(i, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 96'(bus.op_ready), 96'(1));
        chk("rst_done_err", 96'({bus.done, bus.inv_err, bus.res_hit}), 96'(0));
        chk("rst_strobes", 96'({w_en, clr_en}), 96'(0));
        chk("rst_search", 96'({s_vppn, s_asid, t_index, w_index}), 96'(0));
        chk("rst_res", 96'({bus.res_index, bus.res_entry}), 96'(0));
        reset = 1'b0;

        do_write(3'd2, 4'd5, mk(19'h12345, 1'b0, 10'h3, 1'b0), 1'b0, 6'h00);
        do_srch(19'h12345, 10'h3);
        chk("srch_direct_index5", 96'(ridx), 96'(5));
        do_srch(19'h12345, 10'h4);
        do_rd(4'd5);
        load(7, mk(19'h0ABCD, 1'b1, 10'h2, 1'b0));
        do_rd(4'd7);
        chk("rd_invalid_zero", 96'(rent), 96'(0));
        repeat ($urandom_range(0, 7)) @(posedge clk);
        #1;
        do_write(3'd3, 4'd0, mk(19'h00777, 1'b0, 10'h1, 1'b0), 1'b0, 6'h00);
        do_write(3'd2, 4'd11, mk(19'h00042, 1'b1, 10'h5, 1'b0), 1'b1, 6'h3F);
        do_write(3'd2, 4'd12, mk(19'h00043, 1'b0, 10'h5, 1'b1), 1'b1, 6'h00);

        for (int i = 0; i < N; i++) load(i, mk(19'($urandom), 1'b0, 10'h7, 1'b1));
        load(2, mk(19'h12345, 1'b1, 10'h3, 1'b1));
        load(5, mk(19'h12345, 1'b0, 10'h3, 1'b1));
        load(9, mk(19'h0ABCD, 1'b0, 10'h3, 1'b1));
        do_inv(3'd4, 5'd4, 10'h3, 19'h0);
        chk("inv_direct_5_9", 96'(clrs), 96'(16'h0220));
        do_inv(3'd4, 5'd7, 10'h3, 19'h0);
        do_inv(3'd6, 5'd0, 10'h3, 19'h0);

        for (int i = 0; i < N; i++) load(i, mk(pick_vppn(), 1'($urandom), pick_asid(), 1'($urandom)));
        for (int n = 0; n < 60; n++) begin
            int r = $urandom_range(0, 9);
            if (r <= 1) do_srch(pick_vppn(), pick_asid());
            else if (r <= 3) do_rd(IW'($urandom));
            else if (r <= 5) do_write(r == 4 ? 3'd2 : 3'd3, IW'($urandom),
                                      mk(pick_vppn(), 1'($urandom), pick_asid(), 1'($urandom)),
                                      1'($urandom), $urandom_range(0, 1) == 1 ? 6'h3F : 6'($urandom));
            else if (r <= 8) do_inv(3'd4, 5'($urandom_range(0, 6)), pick_asid(), pick_vppn());
            else if ($urandom_range(0, 1) == 1) do_inv(3'($urandom_range(5, 7)), 5'($urandom), pick_asid(), pick_vppn());
            else do_inv(3'd4, 5'($urandom_range(7, 31)), pick_asid(), pick_vppn());
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (tlb[i] !== ref_mem[i]) bad++;
        chk("tlb_image", 96'(bad), 96'(0));

        for (int i = 0; i < N; i++) load(i, mk(19'($urandom), 1'($urandom), 10'($urandom), 1'b1));
        bus.op_code = 3'd4; bus.inv_op = 5'd1; bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_scan_at8", 96'(t_index), 96'(8));
        chk("abort_clr_at8", 96'(clr_en), 96'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", 96'(bus.op_ready), 96'(1));
        chk("abort_quiet", 96'({bus.done, clr_en, w_en}), 96'(0));
        do_write(3'd3, 4'd0, mk(19'h00100, 1'b0, 10'h1, 1'b0), 1'b0, 6'h00);
        chk("abort_fill_ctr_zero", 96'(widx), 96'(0));
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (w_en || clr_en || bus.done) pulses++;
        end
        chk("idle_no_pulses", 96'(pulses), 96'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
